// File: rtl/mxbus_rd_arbiter_pkg.sv
// Shared types and helpers for the MX Bus read/write channel arbiters.
package mxbus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } arb_state_t;

   // Width of a counter that must hold 0..timeout inclusive.
   function automatic int unsigned timer_width(input int unsigned timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mxbus_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module mxbus_rr_pick #(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       ptr,
   output logic                   valid,
   output logic [IDX_W-1:0]       grant
);

   always_comb begin
      int unsigned idx;
      valid = 1'b0;
      grant = '0;
      idx   = 0;
      for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
         idx = 32'(ptr) + off;
         if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
         if (!valid && req[idx[IDX_W-1:0]]) begin
            valid = 1'b1;
            grant = idx[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mxbus_rd_arbiter.sv
// Round-robin arbiter sharing one MX Bus read slave between NUM_MASTERS masters,
// with a watchdog that error-completes transactions the slave never finishes.
module mxbus_rd_arbiter
   import mxbus_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned TIMEOUT     = 15
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS-1:0]            m_rd_txn_start,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_rd_addr,
   output logic                              m_rd_ready,
   output logic [NUM_MASTERS-1:0]            m_rd_txn_ack,
   output logic [NUM_MASTERS-1:0]            m_rd_txn_cpl,
   output logic [NUM_MASTERS-1:0]            m_rd_err,
   output logic [DATA_WIDTH-1:0]             m_rd_data,
   output logic                              s_rd_txn_start,
   output logic [ADDR_WIDTH-1:0]             s_rd_addr,
   input  logic                              s_rd_ready,
   input  logic [DATA_WIDTH-1:0]             s_rd_data,
   input  logic                              s_rd_txn_ack,
   input  logic                              s_rd_txn_cpl
);

   localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
   localparam int unsigned TMR_W = timer_width(TIMEOUT);

   arb_state_t                state, state_d;
   logic [NUM_MASTERS-1:0]    pending, pending_d, set_mask, clr_mask;
   logic [ADDR_WIDTH-1:0]     addr_q [NUM_MASTERS];
   logic [IDX_W-1:0]          ptr, gnt_q, pick_idx, ptr_adv;
   logic                      pick_valid;
   logic [TMR_W-1:0]          timer;
   logic                      grant_now, done_ok, done_err, done;
   logic                      s_start_d;
   logic [ADDR_WIDTH-1:0]     s_addr_d;
   logic [NUM_MASTERS-1:0]    ack_d, cpl_d, err_d;
   logic [DATA_WIDTH-1:0]     data_d;
   logic                      s_ack_unused;

   assign s_ack_unused = s_rd_txn_ack;

   function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   mxbus_rr_pick #(
      .NUM_MASTERS(NUM_MASTERS),
      .IDX_W      (IDX_W)
   ) u_pick (
      .req  (pending),
      .ptr  (ptr),
      .valid(pick_valid),
      .grant(pick_idx)
   );

   // A start on the edge that completes the same master re-arms it (set wins over clear).
   always_comb begin
      grant_now = (state == IDLE) && s_rd_ready && pick_valid;
      done_ok   = (state == WAIT) && s_rd_txn_cpl;
      done_err  = (state == WAIT) && !s_rd_txn_cpl && (timer == TMR_W'(TIMEOUT - 1));
      done      = done_ok || done_err;
      clr_mask  = done ? onehot(gnt_q) : '0;
      set_mask  = m_rd_txn_start & (~pending | clr_mask);
      pending_d = (pending & ~clr_mask) | set_mask;
      ptr_adv   = (gnt_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (grant_now) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_start_d = grant_now;
      s_addr_d  = grant_now ? addr_q[pick_idx] : '0;
      ack_d     = grant_now ? onehot(pick_idx) : '0;
      cpl_d     = clr_mask;
      err_d     = done_err ? onehot(gnt_q) : '0;
      data_d    = done_ok ? s_rd_data : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending        <= '0;
         ptr            <= '0;
         gnt_q          <= '0;
         timer          <= '0;
         m_rd_ready     <= 1'b0;
         m_rd_txn_ack   <= '0;
         m_rd_txn_cpl   <= '0;
         m_rd_err       <= '0;
         m_rd_data      <= '0;
         s_rd_txn_start <= 1'b0;
         s_rd_addr      <= '0;
      end else begin
         pending        <= pending_d;
         if (grant_now) gnt_q <= pick_idx;
         if (done)      ptr   <= ptr_adv;
         timer          <= ((state == WAIT) && !done) ? timer + 1'b1 : '0;
         m_rd_ready     <= s_rd_ready;
         m_rd_txn_ack   <= ack_d;
         m_rd_txn_cpl   <= cpl_d;
         m_rd_err       <= err_d;
         m_rd_data      <= data_d;
         s_rd_txn_start <= s_start_d;
         s_rd_addr      <= s_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (set_mask[i]) addr_q[i] <= m_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

endmodule

// File: tb/tb_mxbus_rd_arbiter.sv
// Scoreboard bench for mxbus_rd_arbiter: a transaction-level model predicts acks and
// completions with their cycle numbers; a monitor matches them against the DUT.
module tb_mxbus_rd_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int unsigned TO = 15;

   logic              clk, rst;
   logic [N-1:0]      m_rd_txn_start;
   logic [N*AW-1:0]   m_rd_addr;
   logic              m_rd_ready;
   logic [N-1:0]      m_rd_txn_ack, m_rd_txn_cpl, m_rd_err;
   logic [DW-1:0]     m_rd_data;
   logic              s_rd_txn_start;
   logic [AW-1:0]     s_rd_addr;
   logic              s_rd_ready;
   logic [DW-1:0]     s_rd_data;
   logic              s_rd_txn_ack, s_rd_txn_cpl;
   logic              slv_cpl, stray_cpl, mute;
   logic [DW-1:0]     mem [256];

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct {int cyc; int mst; int addr;} ack_t;
   typedef struct {int cyc; int mst; bit err; int data;} cpl_t;
   ack_t ackq[$];
   cpl_t cplq[$];

   // reference model state
   bit pend [N];
   int paddr [N];
   int ptr = 0, owner = -1, done_at = 0, free_at = 0;
   bit exp_ready = 0;

   mxbus_rd_arbiter #(
      .NUM_MASTERS(N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .m_rd_txn_start(m_rd_txn_start),
      .m_rd_addr     (m_rd_addr),
      .m_rd_ready    (m_rd_ready),
      .m_rd_txn_ack  (m_rd_txn_ack),
      .m_rd_txn_cpl  (m_rd_txn_cpl),
      .m_rd_err      (m_rd_err),
      .m_rd_data     (m_rd_data),
      .s_rd_txn_start(s_rd_txn_start),
      .s_rd_addr     (s_rd_addr),
      .s_rd_ready    (s_rd_ready),
      .s_rd_data     (s_rd_data),
      .s_rd_txn_ack  (s_rd_txn_ack),
      .s_rd_txn_cpl  (s_rd_txn_cpl)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle slave memory; mute suppresses completions to provoke the watchdog.
   always @(posedge clk) begin
      s_rd_data <= s_rd_txn_start ? mem[s_rd_addr] : DW'($urandom);
      if (rst) begin
         slv_cpl      <= 1'b0;
         s_rd_txn_ack <= 1'b0;
      end else begin
         slv_cpl      <= s_rd_txn_start && !mute;
         s_rd_txn_ack <= s_rd_txn_start;
      end
   end
   assign s_rd_txn_cpl = slv_cpl | stray_cpl;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model of one clock edge c, from the inputs that the DUT will sample there.
   task automatic model_edge(input int c);
      int g;
      if (rst) begin
         for (int i = 0; i < N; i++) pend[i] = 0;
         ptr = 0; owner = -1; free_at = c + 1; exp_ready = 0;
         ackq.delete();
         cplq.delete();
         return;
      end
      exp_ready = s_rd_ready;
      if (owner >= 0 && c == done_at) begin
         pend[owner] = 0;
         ptr = (owner + 1) % N;
         owner = -1;
         free_at = c + 1;
      end else if (owner < 0 && c >= free_at && s_rd_ready) begin
         g = -1;
         for (int k = 0; k < N; k++)
            if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
         if (g >= 0) begin
            owner = g;
            done_at = mute ? c + 1 + TO : c + 2;
            ackq.push_back('{c, g, paddr[g]});
            cplq.push_back('{done_at, g, mute, mute ? 0 : int'(mem[paddr[g]])});
         end
      end
      for (int i = 0; i < N; i++) begin
         if (m_rd_txn_start[i] && !pend[i]) begin
            pend[i] = 1;
            paddr[i] = int'(m_rd_addr[i*AW +: AW]);
         end
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queued predictions.
   initial begin
      ack_t a;
      cpl_t p;
      forever begin
         @(negedge clk);
         check("m_rd_ready", 32'(m_rd_ready), 32'(exp_ready));
         if (m_rd_txn_ack != 0 || s_rd_txn_start) begin
            if (ackq.size() == 0) begin
               check("ack_unexpected", 32'(m_rd_txn_ack), 0);
               check("s_start_unexpected", 32'(s_rd_txn_start), 0);
            end else begin
               a = ackq.pop_front();
               check("ack_cycle", cyc, a.cyc);
               check("ack_vec", 32'(m_rd_txn_ack), 32'(1) << a.mst);
               check("s_start", 32'(s_rd_txn_start), 1);
               check("s_addr", 32'(s_rd_addr), a.addr);
            end
         end else if (ackq.size() > 0 && ackq[0].cyc <= cyc) begin
            a = ackq.pop_front();
            check("ack_missing", 32'(m_rd_txn_ack), 32'(1) << a.mst);
         end
         if (m_rd_txn_cpl != 0 || m_rd_err != 0) begin
            if (cplq.size() == 0) begin
               check("cpl_unexpected", 32'(m_rd_txn_cpl), 0);
               check("err_unexpected", 32'(m_rd_err), 0);
            end else begin
               p = cplq.pop_front();
               check("cpl_cycle", cyc, p.cyc);
               check("cpl_vec", 32'(m_rd_txn_cpl), 32'(1) << p.mst);
               check("err_vec", 32'(m_rd_err), p.err ? 32'(1) << p.mst : 0);
               check("cpl_data", 32'(m_rd_data), p.data);
            end
         end else begin
            check("idle_data", 32'(m_rd_data), 0);
            if (cplq.size() > 0 && cplq[0].cyc <= cyc) begin
               p = cplq.pop_front();
               check("cpl_missing", 32'(m_rd_txn_cpl), 32'(1) << p.mst);
            end
         end
      end
   end

   task automatic step();
      model_edge(cyc + 1);
      @(posedge clk);
      @(negedge clk);
      #1;
      m_rd_txn_start = '0;
      stray_cpl = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic req(input int m, input int a);
      m_rd_txn_start[m] = 1'b1;
      m_rd_addr[m*AW +: AW] = AW'(a);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      m_rd_txn_start = '0;
      m_rd_addr = '0;
      s_rd_ready = 1'b1;
      mute = 1'b0;
      stray_cpl = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
      mem[8'h35] = 8'hA7;
      @(negedge clk);
      #1;
      do_reset();

      // reset state
      check("rst_ack", 32'(m_rd_txn_ack), 0);
      check("rst_cpl", 32'(m_rd_txn_cpl), 0);
      check("rst_err", 32'(m_rd_err), 0);
      check("rst_data", 32'(m_rd_data), 0);
      check("rst_s_start", 32'(s_rd_txn_start), 0);
      check("rst_s_addr", 32'(s_rd_addr), 0);

      // single request: master 2, addr 0x35 -> data 0xA7
      req(2, 8'h35);
      idle(6);

      // simultaneous requests from ptr=0
      do_reset();
      req(0, $urandom_range(0, 255));
      req(1, $urandom_range(0, 255));
      req(3, $urandom_range(0, 255));
      idle(12);

      // round-robin: master 0 hammers, master 3 requests once
      do_reset();
      for (int i = 0; i < 15; i++) begin
         req(0, $urandom_range(0, 255));
         if (i == 2) req(3, $urandom_range(0, 255));
         step();
      end
      idle(6);

      // timeout on master 1, then stray completion while idle
      mute = 1'b1;
      req(1, $urandom_range(0, 255));
      idle(20);
      stray_cpl = 1'b1;
      step();
      idle(2);
      // stray completion landing in ISSUE must be ignored
      req(0, $urandom_range(0, 255));
      idle(2);
      stray_cpl = 1'b1;
      idle(20);
      mute = 1'b0;
      idle(2);

      // not ready, with a duplicate start that must keep the first address
      s_rd_ready = 1'b0;
      req(0, 8'h11);
      idle(3);
      req(0, 8'h22);
      idle(2);
      s_rd_ready = 1'b1;
      idle(6);

      // reset while waiting, masters 1 and 2 pending
      mute = 1'b1;
      req(1, $urandom_range(0, 255));
      req(2, $urandom_range(0, 255));
      idle(5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      mute = 1'b0;
      check("rst_mid_cpl", 32'(m_rd_txn_cpl), 0);
      check("rst_mid_ack", 32'(m_rd_txn_ack), 0);
      check("rst_mid_s_start", 32'(s_rd_txn_start), 0);
      idle(25);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         for (int m = 0; m < N; m++)
            if ($urandom_range(0, 3) == 0) req(m, $urandom_range(0, 255));
         s_rd_ready = ($urandom_range(0, 4) != 0);
         step();
      end
      s_rd_ready = 1'b1;
      idle(40);

      check("ackq_drained", ackq.size(), 0);
      check("cplq_drained", cplq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
